// File: rtl/unstripe_scheduler_if.sv
// Stripe-lane push side and demux-side valid/ready output of the unstripe scheduler.
// The master modport is the environment side; the slave modport is the scheduler.
interface unstripe_scheduler_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_stripe_0;
  logic             valid_stripe_0;
  logic [WIDTH-1:0] data_stripe_1;
  logic             valid_stripe_1;
  logic [WIDTH-1:0] data_demux;
  logic             valid_demux;
  logic             ready_demux;
  logic             fifo_full_0;
  logic             fifo_full_1;
  logic             overflow_err;
  logic             expect_lane;

  modport master (
    output data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1, ready_demux,
    input  data_demux, valid_demux, fifo_full_0, fifo_full_1, overflow_err, expect_lane
  );

  modport slave (
    input  data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1, ready_demux,
    output data_demux, valid_demux, fifo_full_0, fifo_full_1, overflow_err, expect_lane
  );
endinterface

// File: rtl/unstripe_scheduler.sv
// Two-lane unstripe scheduler: per-lane FIFOs popped in strict lane 0/1 alternation
// into a registered valid/ready output stage, with sticky overflow detection.
module unstripe_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk_2f,
  input logic                  reset,
  unstripe_scheduler_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [0:0] {Sel0, Sel1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [CW-1:0]    count_q [2];
  logic [CW-1:0]    count_d [2];
  logic [WIDTH-1:0] push_data [2];
  logic [1:0]       push_v, full, pop, wr_en;
  logic [1:0]       full_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             stage_free, cur_lane;

  assign push_v       = {bus.valid_stripe_1, bus.valid_stripe_0};
  assign push_data[0] = bus.data_stripe_0;
  assign push_data[1] = bus.data_stripe_1;
  assign stage_free   = !valid_q || bus.ready_demux;
  assign cur_lane     = (state_q == Sel1);

  // A push into a full lane survives only if that lane is popped in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    for (int l = 0; l < 2; l++) begin
      full[l]    = (count_q[l] == FullCnt);
      pop[l]     = stage_free && (cur_lane == 1'(l)) && (count_q[l] != '0);
      wr_en[l]   = push_v[l] && (!full[l] || pop[l]);
      count_d[l] = count_q[l] + CW'(wr_en[l]) - CW'(pop[l]);
      if (push_v[l] && !wr_en[l]) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (stage_free) begin
      if (count_q[cur_lane] != '0) begin
        data_d  = mem_q[cur_lane][rd_ptr_q[cur_lane]];
        valid_d = 1'b1;
        state_d = (state_q == Sel0) ? Sel1 : Sel0;
      end else begin
        // Bubble: the other lane is never served out of turn.
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) state_q <= Sel0;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        count_q[l]  <= '0;
      end
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int l = 0; l < 2; l++) begin
        if (wr_en[l]) begin
          mem_q[l][wr_ptr_q[l]] <= push_data[l];
          wr_ptr_q[l]           <= wr_ptr_q[l] + AW'(1);
        end
        if (pop[l]) rd_ptr_q[l] <= rd_ptr_q[l] + AW'(1);
        count_q[l] <= count_d[l];
        full_q[l]  <= (count_d[l] == FullCnt);
      end
    end
  end

  assign bus.data_demux   = data_q;
  assign bus.valid_demux  = valid_q;
  assign bus.fifo_full_0  = full_q[0];
  assign bus.fifo_full_1  = full_q[1];
  assign bus.overflow_err = ovf_q;
  assign bus.expect_lane  = cur_lane;
endmodule

// File: tb/tb_unstripe_scheduler.sv
// Self-checking bench for unstripe_scheduler: queue-based reference model feeds a
// scoreboard of expected output bytes; a negedge monitor checks status and handshakes.
module tb_unstripe_scheduler;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unstripe_scheduler_if #(.WIDTH(WIDTH)) bus ();

  unstripe_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_2f (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: lane contents as byte queues, plus the output register.
  logic [WIDTH-1:0] lane0[$];
  logic [WIDTH-1:0] lane1[$];
  logic [WIDTH-1:0] sb[$];
  bit               m_valid = 1'b0;
  bit               m_lane  = 1'b0;
  bit               m_ovf   = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  bit               end_check = 1'b0;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit               popped;
    logic [WIDTH-1:0] b;
    popped = 1'b0;
    b      = '0;
    if (reset) begin
      lane0.delete();
      lane1.delete();
      sb.delete();
      m_valid = 1'b0;
      m_lane  = 1'b0;
      m_ovf   = 1'b0;
      m_data  = '0;
      return;
    end
    if (!m_valid || bus.ready_demux) begin
      if (!m_lane && lane0.size() > 0) begin
        b = lane0.pop_front();
        popped = 1'b1;
      end else if (m_lane && lane1.size() > 0) begin
        b = lane1.pop_front();
        popped = 1'b1;
      end
      if (popped) begin
        m_data  = b;
        m_valid = 1'b1;
        m_lane  = !m_lane;
        sb.push_back(b);
      end else begin
        m_valid = 1'b0;
      end
    end
    // Pops above free space before pushes; an empty lane cannot pop a same-cycle push.
    if (bus.valid_stripe_0) begin
      if (lane0.size() < DEPTH) lane0.push_back(bus.data_stripe_0);
      else m_ovf = 1'b1;
    end
    if (bus.valid_stripe_1) begin
      if (lane1.size() < DEPTH) lane1.push_back(bus.data_stripe_1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(input bit rst, input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit rdy);
    reset              = rst;
    bus.valid_stripe_0 = v0;
    bus.data_stripe_0  = d0;
    bus.valid_stripe_1 = v1;
    bus.data_stripe_1  = d1;
    bus.ready_demux    = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  // Monitor: compares status every cycle and data on every accepted handshake.
  always @(negedge clk) begin
    logic [4+WIDTH:0] got, exp;
    logic [WIDTH-1:0] e;
    got = {bus.valid_demux, bus.expect_lane, bus.fifo_full_0, bus.fifo_full_1,
           bus.overflow_err, bus.data_demux};
    exp = {m_valid, m_lane, lane0.size() == DEPTH, lane1.size() == DEPTH, m_ovf, m_data};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL status t=%0t got v/lane/f0/f1/ovf/data=%b required %b", $time, got, exp);
    end
    if (!reset && bus.valid_demux && bus.ready_demux) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL output t=%0t got unexpected byte %02h required none", $time,
                 bus.data_demux);
      end else begin
        e = sb.pop_front();
        if (bus.data_demux !== e) begin
          errors++;
          $display("FAIL output t=%0t got %02h required %02h", $time, bus.data_demux, e);
        end
      end
    end
    if (end_check) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d pending bytes required 0", sb.size());
      end
    end
  end

  initial begin
    reset              = 1'b1;
    bus.valid_stripe_0 = 1'b0;
    bus.data_stripe_0  = '0;
    bus.valid_stripe_1 = 1'b0;
    bus.data_stripe_1  = '0;
    bus.ready_demux    = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

    // Balanced stream
    drive(1'b0, 1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
    drive(1'b0, 1'b1, 8'h11, 1'b1, 8'h21, 1'b1);
    idle(4, 1'b1);

    // Skew: lane 1 leads lane 0 by three cycles
    drive(1'b0, 1'b0, '0, 1'b1, 8'hB0, 1'b1);
    idle(2, 1'b1);
    drive(1'b0, 1'b1, 8'hA0, 1'b0, '0, 1'b1);
    idle(3, 1'b1);

    // Backpressure with lane 0 filling up
    drive(1'b0, 1'b1, 8'h10, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, '0, 1'b1, 8'(8'h30 + i), 1'b1);
    idle(4, 1'b1);

    // Overflow, sticky until reset
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, '0, 1'b0);
    idle(3, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(2, 1'b1);

    // Full lane 0 pushed while being popped
    drive(1'b0, 1'b1, 8'h40, 1'b1, 8'h60, 1'b0);
    for (int i = 1; i < 5; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 8'h55, 1'b0, '0, 1'b1);
    for (int i = 1; i < 7; i++) drive(1'b0, 1'b0, '0, 1'b1, 8'(8'h60 + i), 1'b1);
    idle(3, 1'b1);

    // Reset mid-stream with bytes queued
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 8'h77, 1'b1, 8'h78, 1'b1);
    idle(3, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(9) < 7), 8'($urandom),
            ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 7));
    end

    idle(4, 1'b1);
    end_check = 1'b1;
    idle(1, 1'b1);
    end_check = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
